// File: rtl/spw_babasu_link_fsm.sv
// SpaceWire link-startup state machine for the spw_babasu system.
// Sequences ErrorReset -> ErrorWait -> Ready -> Started -> Connecting -> Run
// and drives receiver/transmitter enables as Moore decodes of the state.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_auto_start              level from AUTOSTART PIO
//   i_link_start/_disable     link controls (disable dominates start)
//   i_got_null/_fct/_nchar/_time_code, i_rx_disconnect, i_rx_err,
//   i_credit_error            1-clk event strobes from rx/credit logic
//   o_rx_reset, o_rx_enable, o_tx_enable, o_tx_fct_enable,
//   o_tx_data_enable          receiver/transmitter enables
//   o_link_state[2:0]         current state encoding, o_link_running (Run)
module spw_babasu_link_fsm #(
  parameter int T_6US4  = 320,
  parameter int T_12US8 = 640,
  parameter int CNT_W   = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_auto_start,
  input  logic       i_link_start,
  input  logic       i_link_disable,
  input  logic       i_got_null,
  input  logic       i_got_fct,
  input  logic       i_got_nchar,
  input  logic       i_got_time_code,
  input  logic       i_rx_disconnect,
  input  logic       i_rx_err,
  input  logic       i_credit_error,
  output logic       o_rx_reset,
  output logic       o_rx_enable,
  output logic       o_tx_enable,
  output logic       o_tx_fct_enable,
  output logic       o_tx_data_enable,
  output logic [2:0] o_link_state,
  output logic       o_link_running
);

  typedef enum logic [2:0] {
    S_ERR_RESET  = 3'd0,
    S_ERR_WAIT   = 3'd1,
    S_READY      = 3'd2,
    S_STARTED    = 3'd3,
    S_CONNECTING = 3'd4,
    S_RUN        = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_timer;
  logic               r_null_seen;
  logic               w_tmo6;
  logic               w_tmo12;
  logic               w_err_base;

  assign w_tmo6  = (r_timer == CNT_W'(T_6US4 - 1));
  assign w_tmo12 = (r_timer == CNT_W'(T_12US8 - 1));

  // Parity/escape errors only count once the far end has proven alive with a NULL.
  assign w_err_base = i_rx_disconnect | (i_rx_err & r_null_seen) |
                      i_got_fct | i_got_nchar | i_got_time_code;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_ERR_RESET;
      r_timer     <= '0;
      r_null_seen <= 1'b0;
    end else begin
      r_state <= w_next;
      // Timer restarts on every state change and saturates at all-ones.
      if (w_next != r_state)
        r_timer <= '0;
      else if (!(&r_timer))
        r_timer <= r_timer + 1'b1;
      if (r_state == S_ERR_RESET)
        r_null_seen <= 1'b0;
      else if (i_got_null)
        r_null_seen <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ERR_RESET: begin
        if (w_tmo6) w_next = S_ERR_WAIT;
      end
      S_ERR_WAIT: begin
        if (w_err_base)   w_next = S_ERR_RESET;
        else if (w_tmo12) w_next = S_READY;
      end
      S_READY: begin
        if (w_err_base)
          w_next = S_ERR_RESET;
        else if (!i_link_disable && (i_link_start || (i_auto_start && r_null_seen)))
          w_next = S_STARTED;
      end
      S_STARTED: begin
        // A NULL arriving this very cycle is enough to advance.
        if (w_err_base || i_link_disable || w_tmo12) w_next = S_ERR_RESET;
        else if (r_null_seen || i_got_null)          w_next = S_CONNECTING;
      end
      S_CONNECTING: begin
        if (i_rx_disconnect || i_rx_err || i_link_disable ||
            i_got_nchar || i_got_time_code || w_tmo12)
          w_next = S_ERR_RESET;
        else if (i_got_fct)
          w_next = S_RUN;
      end
      S_RUN: begin
        if (i_rx_disconnect || i_rx_err || i_credit_error || i_link_disable)
          w_next = S_ERR_RESET;
      end
      default: w_next = S_ERR_RESET;
    endcase
  end

  always_comb begin
    o_rx_reset       = 1'b0;
    o_rx_enable      = 1'b0;
    o_tx_enable      = 1'b0;
    o_tx_fct_enable  = 1'b0;
    o_tx_data_enable = 1'b0;
    case (r_state)
      S_ERR_RESET:  o_rx_reset = 1'b1;
      S_ERR_WAIT,
      S_READY:      o_rx_enable = 1'b1;
      S_STARTED: begin
        o_rx_enable = 1'b1;
        o_tx_enable = 1'b1;
      end
      S_CONNECTING: begin
        o_rx_enable     = 1'b1;
        o_tx_enable     = 1'b1;
        o_tx_fct_enable = 1'b1;
      end
      S_RUN: begin
        o_rx_enable      = 1'b1;
        o_tx_enable      = 1'b1;
        o_tx_fct_enable  = 1'b1;
        o_tx_data_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_link_state   = r_state;
  assign o_link_running = (r_state == S_RUN);

endmodule

// File: tb/tb_spw_babasu_link_fsm.sv
// Scoreboard bench for spw_babasu_link_fsm: the stimulus process pushes each
// expected state change (state + cycle at which it must be visible); a monitor
// pops and checks state, enables and timing whenever link_state changes.
module tb_spw_babasu_link_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       auto_start, link_start, link_disable;
  logic       got_null, got_fct, got_nchar, got_time_code;
  logic       rx_disconnect, rx_err, credit_error;
  logic       rx_reset, rx_enable, tx_enable, tx_fct_enable, tx_data_enable;
  logic [2:0] link_state;
  logic       link_running;

  spw_babasu_link_fsm dut (
    .i_clk(clk), .i_reset(reset), .i_auto_start(auto_start),
    .i_link_start(link_start), .i_link_disable(link_disable),
    .i_got_null(got_null), .i_got_fct(got_fct), .i_got_nchar(got_nchar),
    .i_got_time_code(got_time_code), .i_rx_disconnect(rx_disconnect),
    .i_rx_err(rx_err), .i_credit_error(credit_error),
    .o_rx_reset(rx_reset), .o_rx_enable(rx_enable), .o_tx_enable(tx_enable),
    .o_tx_fct_enable(tx_fct_enable), .o_tx_data_enable(tx_data_enable),
    .o_link_state(link_state), .o_link_running(link_running)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] st; int cyc; } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // {rx_reset, rx_enable, tx_enable, tx_fct_enable, tx_data_enable, link_running}
  function automatic logic [5:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd0:    return 6'b100000;
      3'd1:    return 6'b010000;
      3'd2:    return 6'b010000;
      3'd3:    return 6'b011000;
      3'd4:    return 6'b011100;
      3'd5:    return 6'b011111;
      default: return 6'b000000;
    endcase
  endfunction

  initial begin : monitor
    logic [2:0] last;
    logic [5:0] outs;
    exp_t e;
    last = 3'd7;
    forever begin
      @(negedge clk);
      if (mon_en && link_state != last) begin
        last = link_state;
        outs = {rx_reset, rx_enable, tx_enable, tx_fct_enable, tx_data_enable, link_running};
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_transition: got state %0d at cycle %0d, required no change", link_state, cyc);
        end else begin
          e = q.pop_front();
          n_chk++;
          if (link_state !== e.st) begin
            n_fail++;
            $display("FAIL state: got %0d, required %0d (cycle %0d)", link_state, e.st, cyc);
          end
          n_chk++;
          if (outs !== exp_outs(e.st)) begin
            n_fail++;
            $display("FAIL outputs: got %b, required %b (state %0d, cycle %0d)", outs, exp_outs(e.st), e.st, cyc);
          end
          if (e.cyc >= 0) begin
            n_chk++;
            if (cyc != e.cyc) begin
              n_fail++;
              $display("FAIL timing: state %0d seen at cycle %0d, required cycle %0d", e.st, cyc, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] s, input int d);
    exp_t e;
    e.st  = s;
    e.cyc = cyc + d;
    q.push_back(e);
  endtask

  // From Ready with auto_start=1 and null_seen clear: one NULL, then FCT.
  task automatic ready_to_run();
    got_null = 1'b1; push(3'd3, 2); push(3'd4, 3);
    step(1); got_null = 1'b0;
    step(2);
    got_fct = 1'b1; push(3'd5, 1);
    step(1); got_fct = 1'b0;
    step(3);
  endtask

  initial begin : stim
    exp_t e0;
    int t;
    reset = 1'b1;
    {auto_start, link_start, link_disable} = '0;
    {got_null, got_fct, got_nchar, got_time_code} = '0;
    {rx_disconnect, rx_err, credit_error} = '0;

    // Reset state: ErrorReset with rx_reset only.
    e0.st = 3'd0; e0.cyc = -1; q.push_back(e0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(2);
    reset = 1'b0;

    // Power-up sequence: ErrorWait after 320, Ready after 960, stay.
    push(3'd1, 320); push(3'd2, 960);
    step(975);

    // auto_start + NULL -> Started, Connecting, FCT -> Run.
    auto_start = 1'b1;
    ready_to_run();

    // Run, credit_error -> ErrorReset; Ready waits (null_seen cleared).
    credit_error = 1'b1; push(3'd0, 1); push(3'd1, 321); push(3'd2, 961);
    step(1); credit_error = 1'b0;
    step(965);
    ready_to_run();

    // Run, link_disable -> ErrorReset; Ready held by disable despite start.
    link_disable = 1'b1; push(3'd0, 1); push(3'd1, 321); push(3'd2, 961);
    step(965);
    got_null = 1'b1; link_start = 1'b1;
    step(1); got_null = 1'b0;
    step(20);
    link_disable = 1'b0; push(3'd3, 1); push(3'd4, 2);
    step(2);

    // Connecting, FCT and rx_err together -> ErrorReset; then Started
    // without NULL times out after 640.
    got_fct = 1'b1; rx_err = 1'b1;
    push(3'd0, 1); push(3'd1, 321); push(3'd2, 961);
    push(3'd3, 962); push(3'd0, 1602); push(3'd1, 1922);
    t = cyc;
    step(1); got_fct = 1'b0; rx_err = 1'b0;
    step(1700); link_start = 1'b0;
    step(t + 1922 - cyc);

    // ErrorWait: rx_err before NULL ignored, after NULL -> ErrorReset.
    rx_err = 1'b1;
    step(1); rx_err = 1'b0; got_null = 1'b1;
    step(1); got_null = 1'b0; rx_err = 1'b1;
    push(3'd0, 1); push(3'd1, 321); push(3'd2, 961);
    step(1); rx_err = 1'b0;
    // Strobes inside ErrorReset are ignored.
    step(5);
    got_fct = 1'b1; rx_disconnect = 1'b1;
    step(1); got_fct = 1'b0; rx_disconnect = 1'b0;
    step(961);

    // Reset mid-operation wins over a same-cycle strobe.
    reset = 1'b1; got_null = 1'b1; push(3'd0, 1);
    step(2);
    reset = 1'b0; got_null = 1'b0; push(3'd1, 320);
    step(330);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d expected transitions never seen, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
